// File: rtl/pc_sp_unit_pkg.sv
// Shared encodings for the PC/SP register stage: next-PC sources, stack
// operations and the stack-pointer occupancy classes.
package pc_sp_unit_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        PCS_MEM = 2'b00,   // return address from memory (RET)
        PCS_JMP = 2'b01,   // zero-extended J/CALL immediate
        PCS_INC = 2'b10,   // combinational ALU result (PC+1)
        PCS_BR  = 2'b11    // registered ALU output (branch target)
    } pc_src_e;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_RSVD = 2'b11
    } stk_op_e;

    typedef enum logic [1:0] {
        SPC_NORMAL = 2'b00,
        SPC_EMPTY  = 2'b01,
        SPC_FULL   = 2'b10
    } sp_class_e;

endpackage

// File: rtl/pc_sp_unit_stack_ptr.sv
// Stack pointer register with bounds checking: full-descending stack that
// never wraps, plus sticky overflow/underflow status.
module stack_ptr
    import pc_sp_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'('h00FF),
    parameter logic [ADDR_W-1:0] SP_MIN   = ADDR_W'('h00C0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_stack_op,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_stack_ovf,
    output logic              o_stack_unf
);

    logic [ADDR_W-1:0] r_sp;
    logic              r_ovf;
    logic              r_unf;

    sp_class_e         w_class;
    logic [ADDR_W-1:0] w_sp_next;
    logic              w_ovf_set;
    logic              w_unf_set;

    always_comb begin
        if (r_sp == SP_RESET)
            w_class = SPC_EMPTY;
        else if (r_sp == SP_MIN)
            w_class = SPC_FULL;
        else
            w_class = SPC_NORMAL;
    end

    // A refused push/pop leaves sp untouched and only raises the status bit.
    always_comb begin
        w_sp_next = r_sp;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (i_stack_op)
            STK_PUSH: begin
                if (w_class == SPC_FULL)
                    w_ovf_set = 1'b1;
                else
                    w_sp_next = r_sp - ADDR_W'(1);
            end
            STK_POP: begin
                if (w_class == SPC_EMPTY)
                    w_unf_set = 1'b1;
                else
                    w_sp_next = r_sp + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp  <= SP_RESET;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_next;
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    assign o_sp        = r_sp;
    assign o_stack_ovf = r_ovf;
    assign o_stack_unf = r_unf;

endmodule

// File: rtl/pc_sp_unit.sv
// Program-counter and stack-pointer stage fed by the multicycle controller:
// branch condition evaluation, next-PC mux and the architectural PC/SP.
module pc_sp_unit
    import pc_sp_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'('h00FF),
    parameter logic [ADDR_W-1:0] SP_MIN   = ADDR_W'('h00C0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              ALUZeroCond,
    input  logic              BLTCond,
    input  logic              BGTCond,
    input  logic [1:0]        PCSource,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [ADDR_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [1:0]        stack_op,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic              pc_loaded,
    output logic              branch_taken,
    output logic              stack_ovf,
    output logic              stack_unf
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_loaded;
    logic              r_branch_taken;

    logic              w_cond;
    logic              w_load;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_sp;
    logic              w_stack_ovf;
    logic              w_stack_unf;

    // BEQ/BNE share one enable; ALUZeroCond picks which polarity of zero wins.
    assign w_cond = (PCWriteCond & (alu_zero == ALUZeroCond))
                  | (BLTCond & alu_neg)
                  | (BGTCond & ~alu_neg & ~alu_zero);
    assign w_load = PCWrite | w_cond;

    always_comb begin
        w_next_pc = r_pc;
        case (PCSource)
            PCS_MEM: w_next_pc = mem_data;
            PCS_JMP: w_next_pc = jump_target;
            PCS_INC: w_next_pc = alu_result;
            PCS_BR:  w_next_pc = alu_out;
            default: w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= PC_RESET;
            r_pc_loaded    <= 1'b0;
            r_branch_taken <= 1'b0;
        end else begin
            if (w_load)
                r_pc <= w_next_pc;
            r_pc_loaded    <= w_load;
            r_branch_taken <= w_cond & ~PCWrite;
        end
    end

    stack_ptr #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET),
        .SP_MIN   (SP_MIN)
    ) u_stack_ptr (
        .clk         (clk),
        .rst         (rst),
        .i_stack_op  (stack_op),
        .o_sp        (w_sp),
        .o_stack_ovf (w_stack_ovf),
        .o_stack_unf (w_stack_unf)
    );

    assign pc           = r_pc;
    assign sp           = w_sp;
    assign pc_loaded    = r_pc_loaded;
    assign branch_taken = r_branch_taken;
    assign stack_ovf    = w_stack_ovf;
    assign stack_unf    = w_stack_unf;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Directed plus random bench for pc_sp_unit against a behavioural model that
// tracks stack depth and branch decisions from the architectural rules.
module tb_pc_sp_unit;

    localparam int          AW       = 16;
    localparam logic [15:0] SP_TOP   = 16'h00FF;
    localparam int          MAXDEPTH = 63;   // 0x00FF - 0x00C0

    logic          clk = 1'b0;
    logic          rst;
    logic          PCWrite, PCWriteCond, ALUZeroCond, BLTCond, BGTCond;
    logic [1:0]    PCSource;
    logic          alu_zero, alu_neg;
    logic [AW-1:0] alu_result, alu_out, mem_data, jump_target;
    logic [1:0]    stack_op;
    logic [AW-1:0] pc, sp;
    logic          pc_loaded, branch_taken, stack_ovf, stack_unf;

    always #5 clk = ~clk;

    pc_sp_unit dut (
        .clk(clk), .rst(rst),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUZeroCond(ALUZeroCond),
        .BLTCond(BLTCond), .BGTCond(BGTCond), .PCSource(PCSource),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .alu_result(alu_result), .alu_out(alu_out),
        .mem_data(mem_data), .jump_target(jump_target),
        .stack_op(stack_op),
        .pc(pc), .sp(sp), .pc_loaded(pc_loaded), .branch_taken(branch_taken),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;

    logic [15:0] m_pc;
    int          m_depth;
    bit          m_loaded, m_taken, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s step %0d: observed=%h expected=%h", tag, n_step, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; PCWrite = 0; PCWriteCond = 0; ALUZeroCond = 0;
        BLTCond = 0; BGTCond = 0; PCSource = 2'b00;
        alu_zero = 0; alu_neg = 0;
        alu_result = '0; alu_out = '0; mem_data = '0; jump_target = '0;
        stack_op = 2'b00;
    endtask

    // Advance the model from the inputs now on the pins, clock once, compare.
    task automatic step();
        bit          take, ld;
        logic [15:0] tgt;
        if (rst) begin
            m_pc = 16'h0000; m_depth = 0;
            m_loaded = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
        end else begin
            take = 0;
            if (PCWriteCond && ALUZeroCond && alu_zero)   take = 1;  // BEQ
            if (PCWriteCond && !ALUZeroCond && !alu_zero) take = 1;  // BNE
            if (BLTCond && alu_neg)                       take = 1;
            if (BGTCond && !alu_neg && !alu_zero)         take = 1;
            ld = PCWrite || take;
            case (PCSource)
                2'd0: tgt = mem_data;
                2'd1: tgt = jump_target;
                2'd2: tgt = alu_result;
                default: tgt = alu_out;
            endcase
            if (ld) m_pc = tgt;
            m_loaded = ld;
            m_taken  = take && !PCWrite;
            if (stack_op == 2'd1) begin
                if (m_depth < MAXDEPTH) m_depth++; else m_ovf = 1;
            end else if (stack_op == 2'd2) begin
                if (m_depth > 0) m_depth--; else m_unf = 1;
            end
        end
        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d rst=%0b op=%0d pc=%h sp=%h ld=%0b bt=%0b ovf=%0b unf=%0b",
                 n_step, rst, stack_op, pc, sp, pc_loaded, branch_taken, stack_ovf, stack_unf);
        chk("pc", pc, m_pc);
        chk("sp", sp, SP_TOP - 16'(m_depth));
        chk("pc_loaded", 16'(pc_loaded), 16'(m_loaded));
        chk("branch_taken", 16'(branch_taken), 16'(m_taken));
        chk("stack_ovf", 16'(stack_ovf), 16'(m_ovf));
        chk("stack_unf", 16'(stack_unf), 16'(m_unf));
    endtask

    initial begin
        idle();
        m_pc = 16'hxxxx; m_depth = 0;
        rst = 1; step(); step();

        // PC+1
        idle(); PCWrite = 1; PCSource = 2'b10; alu_result = 16'h0001; step();
        // BEQ taken, then not taken
        idle(); PCWriteCond = 1; ALUZeroCond = 1; alu_zero = 1; PCSource = 2'b11; alu_out = 16'h0040; step();
        alu_zero = 0; alu_out = 16'h0077; step();
        // BLT held then taken
        idle(); BLTCond = 1; PCSource = 2'b11; alu_out = 16'h0020; step();
        alu_neg = 1; step();
        // BGT held on zero, then taken
        idle(); PCWrite = 1; PCSource = 2'b01; jump_target = 16'h0000; step();
        idle(); BGTCond = 1; alu_zero = 1; PCSource = 2'b11; alu_out = 16'h0020; step();
        alu_zero = 0; step();
        // BNE taken
        idle(); PCWrite = 1; PCSource = 2'b01; jump_target = 16'h0010; step();
        idle(); PCWriteCond = 1; ALUZeroCond = 0; alu_zero = 0; PCSource = 2'b11; alu_out = 16'h0020; step();
        // CALL then RET
        idle(); PCWrite = 1; PCSource = 2'b01; jump_target = 16'h0123; stack_op = 2'b01; step();
        idle(); PCWrite = 1; PCSource = 2'b00; mem_data = 16'h0005; stack_op = 2'b10; step();
        // Underflow from empty, sticky
        idle(); stack_op = 2'b10; step();
        idle(); step();
        // Fill to SP_MIN, then overflow, then reserved op
        idle(); stack_op = 2'b01;
        for (int i = 0; i < 64; i++) step();
        idle(); stack_op = 2'b11; step();
        idle(); step();
        // Reset during a taken branch with a push pending
        idle(); rst = 1; PCWriteCond = 1; ALUZeroCond = 1; alu_zero = 1;
        PCSource = 2'b11; alu_out = 16'h0040; stack_op = 2'b01; step();

        // Random traffic, pushes biased so the stack walks across its range
        for (int i = 0; i < 600; i++) begin
            idle();
            rst         = ($urandom_range(0, 63) == 0);
            PCWrite     = ($urandom_range(0, 3) == 0);
            PCWriteCond = $urandom_range(0, 1);
            ALUZeroCond = $urandom_range(0, 1);
            BLTCond     = ($urandom_range(0, 3) == 0);
            BGTCond     = ($urandom_range(0, 3) == 0);
            PCSource    = 2'($urandom_range(0, 3));
            alu_zero    = $urandom_range(0, 1);
            alu_neg     = $urandom_range(0, 1);
            alu_result  = 16'($urandom);
            alu_out     = 16'($urandom);
            mem_data    = 16'($urandom);
            jump_target = 16'($urandom);
            stack_op    = (i % 200 < 120) ? 2'($urandom_range(0, 1) + $urandom_range(0, 1) * 0)
                                          : 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
